// File: rtl/pixel_row_readout.sv
// pixel_row_readout
//   Digitises one pixel row and streams it out one word per handshake.
//   During the conversion window each column latches the shared ramp
//   COUNTER on the first cycle its synchronised comparator is high.
//   Columns that never trip are forced to full scale. The stored row is
//   then sent out on a PIXEL_BITS-wide valid/ready channel.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   ERASE                   synchronous clear / abort (highest priority)
//   CONVERT_START/END       one-cycle pulses that open/close the window
//   CMP[W]                  asynchronous per-column comparator outputs
//   COUNTER[B]              shared ramp counter (CLK domain)
//   READ_START              one-cycle pulse that starts readout from HOLD
//   DATA_READY              downstream ready
//   DATA_VALID/OUT/SAT      current word, and its "never tripped" flag
//   PIXEL_INDEX             column of the current word
//   ROW_ID                  constant ROW_INDEX
//   BUSY                    high whenever the engine is not idle
//   ROW_DONE                one-cycle pulse after the last word is taken
module pixel_row_readout #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int PIXEL_BITS        = 8,
    parameter int ROW_INDEX         = 0,
    parameter int IDX_BITS          = $clog2(PIXEL_ARRAY_WIDTH)
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         ERASE,
    input  logic                         CONVERT_START,
    input  logic                         CONVERT_END,
    input  logic [PIXEL_ARRAY_WIDTH-1:0] CMP,
    input  logic [PIXEL_BITS-1:0]        COUNTER,
    input  logic                         READ_START,
    input  logic                         DATA_READY,
    output logic                         DATA_VALID,
    output logic [PIXEL_BITS-1:0]        DATA_OUT,
    output logic                         DATA_SAT,
    output logic [IDX_BITS-1:0]          PIXEL_INDEX,
    output logic [15:0]                  ROW_ID,
    output logic                         BUSY,
    output logic                         ROW_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [IDX_BITS-1:0]   LAST_IDX   = IDX_BITS'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [PIXEL_BITS-1:0] FULL_SCALE = {PIXEL_BITS{1'b1}};

    state_t                         state_r;
    state_t                         next_state_s;
    logic [PIXEL_ARRAY_WIDTH-1:0]   cmp_s1_r;
    logic [PIXEL_ARRAY_WIDTH-1:0]   cmp_s2_r;
    logic [PIXEL_BITS-1:0]          value_r [PIXEL_ARRAY_WIDTH];
    logic [PIXEL_ARRAY_WIDTH-1:0]   captured_r;
    logic [IDX_BITS-1:0]            index_r;
    logic                           row_done_r;
    logic [PIXEL_ARRAY_WIDTH-1:0]   capture_s;
    logic                           handshake_s;
    logic                           last_word_s;

    assign ROW_ID = 16'(ROW_INDEX);

    // Handshake and capture qualifiers shared by next-state and datapath.
    always_comb begin
        handshake_s = (state_r == ST_READOUT) && DATA_READY;
        last_word_s = handshake_s && (index_r == LAST_IDX);
        if (state_r == ST_CONVERT) begin
            capture_s = cmp_s2_r & ~captured_r;
        end else begin
            capture_s = {PIXEL_ARRAY_WIDTH{1'b0}};
        end
    end

    // Two-flop synchroniser for the asynchronous comparator outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmp_s1_r <= {PIXEL_ARRAY_WIDTH{1'b0}};
            cmp_s2_r <= {PIXEL_ARRAY_WIDTH{1'b0}};
        end else begin
            cmp_s1_r <= CMP;
            cmp_s2_r <= cmp_s1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; ERASE overrides every transition.
    always_comb begin
        next_state_s = state_r;
        if (ERASE) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (CONVERT_START) next_state_s = ST_CONVERT;
                    else               next_state_s = ST_IDLE;
                end
                ST_CONVERT: begin
                    if (CONVERT_END) next_state_s = ST_HOLD;
                    else             next_state_s = ST_CONVERT;
                end
                ST_HOLD: begin
                    if (READ_START) next_state_s = ST_READOUT;
                    else            next_state_s = ST_HOLD;
                end
                ST_READOUT: begin
                    if (last_word_s) next_state_s = ST_IDLE;
                    else             next_state_s = ST_READOUT;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Row storage, capture flags, readout index and ROW_DONE pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) value_r[i] <= {PIXEL_BITS{1'b0}};
            captured_r <= {PIXEL_ARRAY_WIDTH{1'b0}};
            index_r    <= {IDX_BITS{1'b0}};
            row_done_r <= 1'b0;
        end else if (ERASE) begin
            for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) value_r[i] <= {PIXEL_BITS{1'b0}};
            captured_r <= {PIXEL_ARRAY_WIDTH{1'b0}};
            index_r    <= {IDX_BITS{1'b0}};
            row_done_r <= 1'b0;
        end else begin
            row_done_r <= last_word_s;
            case (state_r)
                ST_IDLE: begin
                    if (CONVERT_START) captured_r <= {PIXEL_ARRAY_WIDTH{1'b0}};
                end
                ST_CONVERT: begin
                    // A capture on the closing edge beats saturation.
                    for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
                        if (capture_s[i]) begin
                            value_r[i] <= COUNTER;
                        end else if (CONVERT_END && !captured_r[i]) begin
                            value_r[i] <= FULL_SCALE;
                        end
                    end
                    captured_r <= captured_r | capture_s;
                end
                ST_HOLD: begin
                    if (READ_START) index_r <= {IDX_BITS{1'b0}};
                end
                ST_READOUT: begin
                    if (last_word_s)      index_r <= {IDX_BITS{1'b0}};
                    else if (handshake_s) index_r <= index_r + {{(IDX_BITS-1){1'b0}}, 1'b1};
                end
                default: begin
                    index_r <= {IDX_BITS{1'b0}};
                end
            endcase
        end
    end

    // Outputs decoded from registered state; word fields are zero unless valid.
    always_comb begin
        BUSY        = (state_r != ST_IDLE);
        ROW_DONE    = row_done_r;
        PIXEL_INDEX = index_r;
        if (state_r == ST_READOUT) begin
            DATA_VALID = 1'b1;
            DATA_OUT   = value_r[index_r];
            DATA_SAT   = ~captured_r[index_r];
        end else begin
            DATA_VALID = 1'b0;
            DATA_OUT   = {PIXEL_BITS{1'b0}};
            DATA_SAT   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_row_readout.sv
module tb_pixel_row_readout;

    localparam int W    = 8;
    localparam int B    = 8;
    localparam int W2   = 5;
    localparam int B2   = 10;
    localparam int ROW2 = 3;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst_n, erase, convert_start, convert_end, read_start, data_ready;
    logic [W-1:0]  cmp;
    logic [B2-1:0] counter;

    logic          a_valid, a_sat, a_busy, a_done;
    logic [B-1:0]  a_out;
    logic [2:0]    a_idx;
    logic [15:0]   a_row_id;
    logic          b_valid, b_sat, b_busy, b_done;
    logic [B2-1:0] b_out;
    logic [2:0]    b_idx;
    logic [15:0]   b_row_id;

    int tests = 0;
    int fails = 0;

    // Scenario description and reference results
    int            rise [W];   // first edge (relative to CONVERT_START edge 0) with CMP high
    int            conv_len;   // edge index of CONVERT_END
    int            cnt0;       // COUNTER value at edge 0
    logic [B-1:0]  exp_a [W];
    logic [B2-1:0] exp_b [W];
    logic          exp_sat [W];

    always #5 clk = ~clk;

    pixel_row_readout #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(B), .ROW_INDEX(0)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .ERASE(erase), .CONVERT_START(convert_start),
        .CONVERT_END(convert_end), .CMP(cmp), .COUNTER(counter[B-1:0]),
        .READ_START(read_start), .DATA_READY(data_ready), .DATA_VALID(a_valid),
        .DATA_OUT(a_out), .DATA_SAT(a_sat), .PIXEL_INDEX(a_idx), .ROW_ID(a_row_id),
        .BUSY(a_busy), .ROW_DONE(a_done));

    pixel_row_readout #(.PIXEL_ARRAY_WIDTH(W2), .PIXEL_BITS(B2), .ROW_INDEX(ROW2)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .ERASE(erase), .CONVERT_START(convert_start),
        .CONVERT_END(convert_end), .CMP(cmp[W2-1:0]), .COUNTER(counter),
        .READ_START(read_start), .DATA_READY(data_ready), .DATA_VALID(b_valid),
        .DATA_OUT(b_out), .DATA_SAT(b_sat), .PIXEL_INDEX(b_idx), .ROW_ID(b_row_id),
        .BUSY(b_busy), .ROW_DONE(b_done));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a column latches COUNTER at the first conversion edge e (1..conv_len)
    // whose CMP level two edges earlier was high; otherwise it saturates.
    task automatic model_row();
        int cap_e;
        for (int i = 0; i < W; i++) begin
            cap_e = -1;
            for (int e = conv_len; e >= 1; e--) if (e - 2 >= rise[i]) cap_e = e;
            if (cap_e >= 0) begin
                exp_sat[i] = 1'b0;
                exp_a[i]   = B'(cnt0 + cap_e);
                exp_b[i]   = B2'(cnt0 + cap_e);
            end else begin
                exp_sat[i] = 1'b1;
                exp_a[i]   = {B{1'b1}};
                exp_b[i]   = {B2{1'b1}};
            end
        end
    endtask

    task automatic convert_row();
        model_row();
        for (int e = -2; e <= conv_len; e++) begin
            for (int i = 0; i < W; i++) cmp[i] = (e >= rise[i]);
            counter       = B2'(cnt0 + e);
            convert_start = (e == 0);
            convert_end   = (e == conv_len);
            step();
            if (e == 0) begin
                tests++;
                if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_at_start: busy=%0b valid=%0b, want busy=1 valid=0", a_busy, a_valid);
                end
            end
        end
        convert_start = 1'b0;
        convert_end   = 1'b0;
        cmp           = '0;
        tests++;
        if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_state: busy=%0b valid=%0b, want busy=1 valid=0", a_busy, a_valid);
        end
    endtask

    // mode 0: ready always high; mode 1: alternate ready plus 5-cycle stall at index 4.
    // abort_at >= 0: ERASE is applied while that index is presented.
    task automatic read_row(input int mode, input int abort_at);
        int nxt = 0;
        int cyc = 0;
        int stall = 0;
        logic rdy;
        read_start = 1'b1;
        data_ready = 1'b0;
        step();
        read_start = 1'b0;
        while (nxt < W && cyc < 200) begin
            tests++;
            if (a_valid !== 1'b1 || a_idx !== 3'(nxt) || a_out !== exp_a[nxt] || a_sat !== exp_sat[nxt]) begin
                fails++;
                $display("FAIL word[%0d]: valid=%0b idx=%0d out=%h sat=%0b, want valid=1 idx=%0d out=%h sat=%0b",
                         nxt, a_valid, a_idx, a_out, a_sat, nxt, exp_a[nxt], exp_sat[nxt]);
            end
            if (nxt == abort_at) begin
                erase      = 1'b1;
                data_ready = 1'b0;
                step();
                erase = 1'b0;
                return;
            end
            if (mode == 0)                      rdy = 1'b1;
            else if (nxt == 4 && stall < 5) begin rdy = 1'b0; stall++; end
            else                                rdy = (cyc % 2 == 1);
            data_ready = rdy;
            step();
            cyc++;
            if (rdy) nxt++;
        end
        data_ready = 1'b0;
        tests++;
        if (nxt < W) begin
            fails++;
            $display("FAIL read_timeout: words=%0d, want %0d", nxt, W);
        end
        if (mode == 0) begin
            tests++;
            if (cyc !== W) begin
                fails++;
                $display("FAIL throughput: cycles=%0d, want %0d", cyc, W);
            end
        end
        tests++;
        if (a_valid !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL row_done: valid=%0b done=%0b busy=%0b, want 0 1 0", a_valid, a_done, a_busy);
        end
        step();
        tests++;
        if (a_done !== 1'b0) begin
            fails++;
            $display("FAIL row_done_pulse: done=%0b, want 0", a_done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if (a_valid !== 1'b0 || a_out !== '0 || a_sat !== 1'b0 || a_idx !== '0 ||
            a_busy !== 1'b0 || a_done !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid=%0b out=%h sat=%0b idx=%0d busy=%0b done=%0b, want all 0",
                     name, a_valid, a_out, a_sat, a_idx, a_busy, a_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; erase = 1'b0; convert_start = 1'b0; convert_end = 1'b0;
        read_start = 1'b0; data_ready = 1'b0; cmp = '0; counter = '0;
        step();
        step();
        check_idle_outputs("reset_state");
        tests++;
        if (a_row_id !== 16'd0 || b_row_id !== 16'(ROW2)) begin
            fails++;
            $display("FAIL row_id: a=%0d b=%0d, want 0 %0d", a_row_id, b_row_id, ROW2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ignored();
        read_start = 1'b1; step(); read_start = 1'b0;
        convert_end = 1'b1; step(); convert_end = 1'b0;
        erase = 1'b1; convert_start = 1'b1; step(); erase = 1'b0; convert_start = 1'b0;
        check_idle_outputs("ignored_inputs");
    endtask

    task automatic set_rises_linear();
        for (int i = 0; i < W; i++) rise[i] = 10 + i;
    endtask

    task automatic test_basic();
        set_rises_linear(); conv_len = 30; cnt0 = 0;
        convert_row();
        read_row(0, -1);
    endtask

    task automatic test_saturation();
        set_rises_linear(); rise[3] = NEVER; rise[7] = NEVER; conv_len = 25; cnt0 = 0;
        convert_row();
        read_row(0, -1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < W; i++) rise[i] = int'($urandom_range(0, 24)) - 2;
        conv_len = 20; cnt0 = int'($urandom_range(0, 1023));
        convert_row();
        read_row(1, -1);
    endtask

    task automatic test_boundary();
        set_rises_linear(); conv_len = 20; cnt0 = 0;
        rise[0] = -2;             // already high at CONVERT_START
        rise[1] = conv_len - 2;   // captures on the CONVERT_END edge
        convert_row();
        read_row(0, -1);
    endtask

    task automatic test_abort();
        set_rises_linear(); conv_len = 22; cnt0 = 5;
        convert_row();
        read_row(0, 5);
        tests++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            fails++;
            $display("FAIL abort: valid=%0b busy=%0b done=%0b, want 0 0 0", a_valid, a_busy, a_done);
        end
        step();
        tests++;
        if (a_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: done=%0b, want 0", a_done);
        end
        read_start = 1'b1; step(); read_start = 1'b0;
        step();
        check_idle_outputs("read_after_abort");
    endtask

    task automatic test_reset_mid_convert();
        convert_start = 1'b1; step(); convert_start = 1'b0;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_random();
        int hold;
        for (int r = 0; r < 4; r++) begin
            conv_len = int'($urandom_range(12, 30));
            cnt0     = int'($urandom_range(0, 1023));
            for (int i = 0; i < W; i++) rise[i] = int'($urandom_range(0, conv_len + 5)) - 2;
            convert_row();
            hold = int'($urandom_range(0, 6));
            for (int h = 0; h < hold; h++) begin
                step();
                tests++;
                if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL hold_wait: busy=%0b valid=%0b, want 1 0", a_busy, a_valid);
                end
            end
            read_row(int'($urandom_range(0, 1)), -1);
        end
    endtask

    task automatic test_param();
        for (int i = 0; i < W; i++) rise[i] = int'($urandom_range(0, 16)) - 2;
        rise[2] = NEVER; rise[4] = NEVER;
        conv_len = 18; cnt0 = int'($urandom_range(0, 1023));
        convert_row();
        read_start = 1'b1; step(); read_start = 1'b0;
        data_ready = 1'b1;
        for (int k = 0; k < W2; k++) begin
            tests++;
            if (b_valid !== 1'b1 || b_idx !== 3'(k) || b_out !== exp_b[k] || b_sat !== exp_sat[k]) begin
                fails++;
                $display("FAIL p_word[%0d]: valid=%0b idx=%0d out=%h sat=%0b, want valid=1 idx=%0d out=%h sat=%0b",
                         k, b_valid, b_idx, b_out, b_sat, k, exp_b[k], exp_sat[k]);
            end
            step();
        end
        data_ready = 1'b0;
        tests++;
        if (b_valid !== 1'b0 || b_done !== 1'b1 || b_busy !== 1'b0 || b_idx !== 3'd0) begin
            fails++;
            $display("FAIL p_row_done: valid=%0b done=%0b busy=%0b idx=%0d, want 0 1 0 0",
                     b_valid, b_done, b_busy, b_idx);
        end
        tests++;
        if (b_row_id !== 16'(ROW2)) begin
            fails++;
            $display("FAIL p_row_id: %0d, want %0d", b_row_id, ROW2);
        end
        erase = 1'b1; step(); erase = 1'b0;
        tests++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            fails++;
            $display("FAIL p_erase: busy a=%0b b=%0b, want 0 0", a_busy, b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_basic();
        test_saturation();
        test_backpressure();
        test_boundary();
        test_abort();
        test_reset_mid_convert();
        test_random();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Parametrised pixel-row digitiser and serial readout engine. Each column's comparator trip latches the shared ramp COUNTER during a conversion window. Columns that never trip saturate to full scale. The row is then streamed out one pixel per handshake on a narrow valid/ready bus. The block sits between the analog pixel row (comparator outputs) and the array-level readout multiplexer, and replaces the wide tri-stated row bus with a single PIXEL_BITS channel.

## Interface
- PIXEL_ARRAY_WIDTH, default 8: pixels (columns) per row, must be ≥ 2.
- PIXEL_BITS, default 8: counter and pixel value width.
- ROW_INDEX, default 0: static row identifier, echoed on ROW_ID.
- IDX_BITS, default $clog2(PIXEL_ARRAY_WIDTH): pixel index width (derived, not overridden).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ERASE  in  1  synchronous clear/abort; highest priority.
- CONVERT_START  in  1  one-cycle pulse that opens the conversion window.
- CONVERT_END  in  1  one-cycle pulse that closes the conversion window.
- CMP  in  PIXEL_ARRAY_WIDTH  per-column comparator outputs, asynchronous to CLK.
- COUNTER  in  PIXEL_BITS  shared ramp counter, synchronous to CLK.
- READ_START  in  1  one-cycle pulse that starts readout.
- DATA_READY  in  1  downstream ready.
- DATA_VALID  out  1  DATA_OUT/PIXEL_INDEX/DATA_SAT are valid.
- DATA_OUT  out  PIXEL_BITS  pixel value.
- DATA_SAT  out  1  current pixel never tripped (value forced to all ones).
- PIXEL_INDEX  out  IDX_BITS  column of the current word.
- ROW_ID  out  16  constant ROW_INDEX.
- BUSY  out  1  state ≠ IDLE.
- ROW_DONE  out  1  one-cycle pulse after the last word is accepted.

## Operation
- CMP[i] passes through a 2-flop synchroniser per column (cmp_s2[i]).
- Per-column storage: value[i] (PIXEL_BITS bits) and captured[i] (1 bit).

State machine (IDLE, CONVERT, HOLD, READOUT):
- IDLE: on CONVERT_START, clear all captured[i] and go to CONVERT.
- CONVERT: in every cycle where cmp_s2[i]=1 and captured[i]=0, load value[i] <= COUNTER and set captured[i] <= 1. Capture is level-based, so a column already high at entry captures in the first CONVERT cycle. Once captured, a column ignores further CMP activity.
- CONVERT and CONVERT_END: any column with captured=0 after that cycle's captures gets value <= all ones. A capture in the same cycle as CONVERT_END wins for that column. The state then goes to HOLD.
- HOLD: on READ_START, set index <= 0 and go to READOUT.
- READOUT: DATA_VALID=1, DATA_OUT=value[index], DATA_SAT=~captured[index], PIXEL_INDEX=index.
- READOUT handshake: on DATA_VALID & DATA_READY, index increments. At index = PIXEL_ARRAY_WIDTH-1, the state goes to IDLE and ROW_DONE pulses in the next cycle.
- ERASE in any state: go to IDLE, clear all value to 0, clear all captured to 0, clear index to 0, and suppress ROW_DONE. If ERASE and CONVERT_START arrive together, ERASE wins.
- Ignored inputs: CONVERT_START outside IDLE, CONVERT_END outside CONVERT, READ_START outside HOLD.
- HOLD keeps its data indefinitely. Only ERASE or a completed readout leaves HOLD/READOUT.

## Timing
- Reset (RESET_N=0, asynchronous): state=IDLE, all value=0, all captured=0, index=0, synchroniser flops=0. Outputs: DATA_VALID=0, DATA_OUT=0, DATA_SAT=0, PIXEL_INDEX=0, BUSY=0, ROW_DONE=0. Reset release is synchronous to CLK.
- CONVERT_START sampled at edge t: BUSY=1 from t, and CONVERT is active from t.
- Capture latency: CMP rises before edge k, so cmp_s2=1 after edge k+1. The value latched is the COUNTER present at edge k+2, provided the state is CONVERT at that edge.
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- READ_START at edge t: DATA_VALID=1 and PIXEL_INDEX=0 from t.
- Throughput: one word per cycle while DATA_READY is held high. With READY tied high, a full row takes PIXEL_ARRAY_WIDTH cycles.
- Backpressure: while DATA_READY=0, DATA_OUT, DATA_SAT and PIXEL_INDEX hold stable and DATA_VALID stays 1. VALID never drops without a handshake, except on ERASE or reset.
- Last word accepted at edge t: DATA_VALID=0 and ROW_DONE=1 for the cycle after t; BUSY=0 from t.
- Index width: PIXEL_INDEX never exceeds PIXEL_ARRAY_WIDTH-1, including for non-power-of-two widths.

## Test plan
- Basic capture: W=8, B=8, COUNTER incrementing from 0 each cycle starting at CONVERT_START; CMP[i] rises before edge 10+i -> readout gives value[i]=COUNTER at edge 12+i, DATA_SAT=0 for every column, ROW_DONE after 8 accepted words.
- Saturation: CMP[3] and CMP[7] never rise before CONVERT_END -> words 3 and 7 read 0xFF with DATA_SAT=1, all other columns hold their captured values.
- Backpressure: DATA_READY low on alternate cycles, plus a 5-cycle stall on index 4 -> DATA_OUT and PIXEL_INDEX stable through each stall, no word lost or duplicated, indices 0..7 in order.
- Boundary: CMP[0] already high at CONVERT_START -> captures the COUNTER present at the first CONVERT edge; CMP[1] capture in the same cycle as CONVERT_END -> real value captured, DATA_SAT=0.
- Abort: ERASE asserted during READOUT at index 5 -> DATA_VALID=0 next cycle, BUSY=0, no ROW_DONE; a following readout without reconversion is impossible (READ_START in IDLE is ignored). RESET_N pulsed mid-CONVERT -> all outputs return to their reset values immediately.
- Parametrisation: W=5, B=10 -> PIXEL_INDEX is 3 bits and wraps from 4 to IDLE, saturated columns read 0x3FF, ROW_ID equals ROW_INDEX.
